button_conditioner: RTL and testbench

- Front-end stage directly upstream of Setting and the note player.
- Turns raw, bouncy, asynchronous board buttons (8 note keys plus ESC) into clean, synchronised, one-cycle rising-edge pulses on slow_clk.
- Serialises simultaneous key presses, so pose_buts is always one-hot or zero, as Setting's remap sequencing requires.

---
 rtl/organ_pkg.sv | 26 ++
 rtl/button_conditioner_debounce_ch.sv | 49 ++++
 rtl/button_conditioner.sv | 127 ++++++++++++
 tb/tb_button_conditioner.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/organ_pkg.sv
// Shared constants and bit-vector helpers for the organ front end.
package organ_pkg;

  localparam int N_BUTS          = 8;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int REPEAT_DELAY    = 16;
  localparam int REPEAT_PERIOD   = 8;
  localparam int REP_CNT_W       = 5;

  typedef logic [N_BUTS-1:0] but_vec_t;

  // Two's-complement trick isolates the lowest set bit; zero maps to zero.
  function automatic but_vec_t lowest_set(input but_vec_t v);
    return v & (~v + but_vec_t'(1));
  endfunction

  function automatic logic [3:0] popcount(input but_vec_t v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < N_BUTS; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/button_conditioner_debounce_ch.sv
// Single-bit synchroniser + debouncer; rise flags the edge on which stable goes 0->1.
module debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic slow_clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;
  // Combinational so the downstream pulse is registered on the same edge as the flip.
  assign rise   = ~stable_q & stable_d;

endmodule

// File: rtl/button_conditioner.sv
// Debounces 8 note keys plus ESC and serialises key presses into one-hot pulses.
// Optional auto-repeat on held keys: define BUTTON_CONDITIONER_AUTO_REPEAT_EN.
module button_conditioner
  import organ_pkg::*;
#(
  parameter int N_BUTS          = organ_pkg::N_BUTS,
  parameter int DEBOUNCE_CYCLES = organ_pkg::DEBOUNCE_CYCLES,
  parameter int CNT_W           = 3
) (
  input  logic              slow_clk,
  input  logic              rst,
  input  logic [N_BUTS-1:0] raw_buts,
  input  logic              raw_esc,
  output logic [N_BUTS-1:0] pose_buts,
  output logic              pose_esc,
  output logic [N_BUTS-1:0] stable_buts,
  output logic [3:0]        pending_cnt
);

  logic [N_BUTS:0]   raw_all, stable_all, rise_all;
  logic [N_BUTS-1:0] stable_keys, rep_rise;
  logic [N_BUTS-1:0] rise_keys, cand, pick;
  logic [N_BUTS-1:0] pending_q, pending_d;
  logic [N_BUTS-1:0] pose_buts_q, pose_buts_d;
  logic              pose_esc_q, pose_esc_d;
  logic [3:0]        pending_cnt_q, pending_cnt_d;
  logic              unused_stable_esc;

  assign raw_all = {raw_esc, raw_buts};

  for (genvar g = 0; g <= N_BUTS; g++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .slow_clk(slow_clk),
      .rst     (rst),
      .raw     (raw_all[g]),
      .stable  (stable_all[g]),
      .rise    (rise_all[g])
    );
  end

  assign stable_keys       = stable_all[N_BUTS-1:0];
  assign unused_stable_esc = stable_all[N_BUTS];

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
  localparam logic [REP_CNT_W-1:0] REP_DELAY_LAST  = REP_CNT_W'(REPEAT_DELAY - 1);
  localparam logic [REP_CNT_W-1:0] REP_PERIOD_LAST = REP_CNT_W'(REPEAT_PERIOD - 1);

  logic [REP_CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic                 rep_arm_q, rep_arm_d;
  logic [N_BUTS-1:0]    trk_q, trk_d, tracked;
  logic                 rep_restart, rep_due;

  // One shared counter follows the lowest held key; a change of tracked key means it was released.
  always_comb begin
    tracked     = lowest_set(stable_keys);
    rep_restart = (|rise_all) || (tracked == '0) ||
                  ((trk_q != '0) && (tracked != trk_q));
    rep_due     = rep_arm_q ? (rep_cnt_q == REP_PERIOD_LAST)
                            : (rep_cnt_q == REP_DELAY_LAST);
    rep_cnt_d   = rep_cnt_q + REP_CNT_W'(1);
    rep_arm_d   = rep_arm_q;
    rep_rise    = '0;
    trk_d       = tracked;
    if (rep_restart) begin
      rep_cnt_d = '0;
      rep_arm_d = 1'b0;
    end else if (rep_due) begin
      rep_cnt_d = '0;
      rep_arm_d = 1'b1;
      rep_rise  = tracked;
    end
  end

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      rep_cnt_q <= '0;
      rep_arm_q <= 1'b0;
      trk_q     <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_arm_q <= rep_arm_d;
      trk_q     <= trk_d;
    end
  end
`else
  assign rep_rise = '0;
`endif

  // ESC wins over everything queued or rising on the same edge.
  always_comb begin
    rise_keys  = rise_all[N_BUTS-1:0] | rep_rise;
    cand       = pending_q | rise_keys;
    pick       = lowest_set(cand);
    pose_esc_d = rise_all[N_BUTS];
    if (pose_esc_d) begin
      pose_buts_d = '0;
      pending_d   = '0;
    end else begin
      pose_buts_d = pick;
      pending_d   = cand & ~pick;
    end
    pending_cnt_d = popcount(pending_d);
  end

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      pending_q     <= '0;
      pose_buts_q   <= '0;
      pose_esc_q    <= 1'b0;
      pending_cnt_q <= '0;
    end else begin
      pending_q     <= pending_d;
      pose_buts_q   <= pose_buts_d;
      pose_esc_q    <= pose_esc_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

  assign pose_buts   = pose_buts_q;
  assign pose_esc    = pose_esc_q;
  assign stable_buts = stable_keys;
  assign pending_cnt = pending_cnt_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: stimulus queues expected pulses, a monitor checks them.
module tb_button_conditioner;

  localparam int D = 4;

  logic       slow_clk;
  logic       rst;
  logic [7:0] raw_buts;
  logic       raw_esc;
  logic [7:0] pose_buts;
  logic       pose_esc;
  logic [7:0] stable_buts;
  logic [3:0] pending_cnt;

  button_conditioner dut (
    .slow_clk   (slow_clk),
    .rst        (rst),
    .raw_buts   (raw_buts),
    .raw_esc    (raw_esc),
    .pose_buts  (pose_buts),
    .pose_esc   (pose_esc),
    .stable_buts(stable_buts),
    .pending_cnt(pending_cnt)
  );

  initial slow_clk = 1'b0;
  always #5 slow_clk = ~slow_clk;

  int cyc = 0;
  always @(posedge slow_clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [7:0] buts;
    logic       esc;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   key_pulses = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input int c, input logic [7:0] b, input logic e, input logic [3:0] n);
    exp_t x;
    x.c = c; x.buts = b; x.esc = e; x.cnt = n;
    sb.push_back(x);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge slow_clk);
  endtask

  // Monitor: every pulse must match the head of the scoreboard in cycle and value.
  always @(negedge slow_clk) begin
    if (!rst && (pose_buts != 8'h00 || pose_esc)) begin
      exp_t e;
      if (pose_buts != 8'h00) key_pulses++;
      check("onehot", (pose_buts == 8'h00) ? 1 : $countones(pose_buts), 1);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {pose_esc, pose_buts, pending_cnt}, 0);
      end else begin
        e = sb.pop_front();
        check("pulse_cycle", cyc, e.c);
        check("pulse_value", {pose_esc, pose_buts, pending_cnt}, {e.esc, e.buts, e.cnt});
      end
    end
  end

  initial begin
    int         k;
    int         base;
    logic [7:0] one;
    one      = 8'h01;
    rst      = 1'b1;
    raw_buts = 8'h00;
    raw_esc  = 1'b0;

    wait_cyc(3);
    check("rst_pose_buts", pose_buts, 0);
    check("rst_pose_esc", pose_esc, 0);
    check("rst_stable", stable_buts, 0);
    check("rst_pending_cnt", pending_cnt, 0);
    rst = 1'b0;
    wait_cyc(3);

    // Reset mid-debounce, then a clean press
    raw_buts = 8'h01;
    wait_cyc(2);
    rst = 1'b1;
    #1;
    check("midrst_pose_buts", pose_buts, 0);
    check("midrst_stable", stable_buts, 0);
    check("midrst_pending_cnt", pending_cnt, 0);
    @(negedge slow_clk);
    rst = 1'b0;
    k = cyc;
    expect_pulse(k + 2 + D, 8'h01, 1'b0, 4'd0);
    wait_cyc(8);
    check("press0_stable", stable_buts, 8'h01);
    raw_buts = 8'h00;
    wait_cyc(10);

    // Glitch of D-1 cycles is rejected, D-cycle hold is accepted
    raw_buts = 8'h08;
    wait_cyc(3);
    raw_buts = 8'h00;
    wait_cyc(10);
    check("glitch_stable", stable_buts, 0);
    raw_buts = 8'h08;
    k = cyc;
    expect_pulse(k + 2 + D, 8'h08, 1'b0, 4'd0);
    wait_cyc(8);
    check("hold3_stable", stable_buts, 8'h08);
    raw_buts = 8'h00;
    wait_cyc(10);

    // Simultaneous press drains lowest index first
    raw_buts = 8'hA5;
    k = cyc;
    expect_pulse(k + 6, 8'h01, 1'b0, 4'd3);
    expect_pulse(k + 7, 8'h04, 1'b0, 4'd2);
    expect_pulse(k + 8, 8'h20, 1'b0, 4'd1);
    expect_pulse(k + 9, 8'h80, 1'b0, 4'd0);
    wait_cyc(10);
    raw_buts = 8'h00;
    wait_cyc(12);

    // ESC lands on the second emission edge and flushes the queue
    raw_buts = 8'hFF;
    k = cyc;
    @(negedge slow_clk);
    raw_esc = 1'b1;
    expect_pulse(k + 6, 8'h01, 1'b0, 4'd7);
    expect_pulse(k + 7, 8'h00, 1'b1, 4'd0);
    wait_cyc(9);
    check("esc_pending_cnt", pending_cnt, 0);
    raw_buts = 8'h00;
    raw_esc  = 1'b0;
    wait_cyc(12);

    // Keys 0..7 pressed one at a time, ten cycles apart
    base = key_pulses;
    for (int i = 0; i < 8; i++) begin
      raw_buts = one << i;
      k = cyc;
      expect_pulse(k + 6, one << i, 1'b0, 4'd0);
      wait_cyc(10);
    end
    raw_buts = 8'h00;
    wait_cyc(12);
    check("setting_advance", key_pulses - base, 8);

    // Long hold of key 2
    raw_buts = 8'h04;
    k = cyc;
    expect_pulse(k + 6, 8'h04, 1'b0, 4'd0);
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    expect_pulse(k + 22, 8'h04, 1'b0, 4'd0);
    expect_pulse(k + 30, 8'h04, 1'b0, 4'd0);
    expect_pulse(k + 38, 8'h04, 1'b0, 4'd0);
`endif
    wait_cyc(36);
    raw_buts = 8'h00;
    wait_cyc(20);

    check("sb_drained", sb.size(), 0);
    check("final_pending_cnt", pending_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
